// File: rtl/tt_um_felixfeierabend_mux_pkg.sv
// -----------------------------------------------------------------------------
// tt_um_felixfeierabend_mux_pkg
// Shared definitions for the source-select mux design:
//   - sel_e      : 2-bit source-select encodings carried on uio_in[5:4]
//   - LFSR_SEED  : value the LFSR is reset to (the all-zero state is a lock-up)
//   - LFSR_TAPS  : feedback tap mask, bits 7,5,4,3
//   - UIO_OE     : fixed bidirectional pad direction (low nibble driven)
// -----------------------------------------------------------------------------
package tt_um_felixfeierabend_mux_pkg;

  typedef enum logic [1:0] {
    SEL_UI   = 2'd0,
    SEL_HOLD = 2'd1,
    SEL_CNT  = 2'd2,
    SEL_LFSR = 2'd3
  } sel_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] UIO_OE    = 8'h0F;

endpackage

// File: rtl/tt_um_felixfeierabend_mux_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR, maximal length (255 states, never 00).
// Shifts left once per enabled cycle; the new LSB is the XOR of the
// tapped bits q[7]^q[5]^q[4]^q[3].
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads LFSR_SEED
//   en    - shift enable; low holds the state
//   q     - current LFSR state
// -----------------------------------------------------------------------------
module lfsr8
  import tt_um_felixfeierabend_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_reg;
  logic [7:0] q_next;

  // Shift path: each bit takes its lower neighbour.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi-1];
    end
  endgenerate

  // Feedback into bit 0: reduction XOR over the tapped bits.
  assign q_next[0] = ^(q_reg & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= LFSR_SEED;
    end else if (en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/tt_um_felixfeierabend_mux.sv
// -----------------------------------------------------------------------------
// tt_um_felixfeierabend_mux
// Registered 4-way source mux with optional output inversion.
// Sources: ui_in, a loadable hold register, a free-running 8-bit counter and
// an 8-bit LFSR. Everything advances only when ena is high.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   ena        - global enable; low freezes every register
//   ui_in      - data input (source 0 and hold-register load data)
//   uio_in     - [5:4] sel, [6] load, [7] invert, [3:0] unused
//   uo_out     - registered mux result (1-cycle latency)
//   uio_out    - [0] counter wrap pulse, [1] hold_valid, [3:2] sel echo,
//                [7:4] zero
//   uio_oe     - constant 8'h0F (low nibble driven, high nibble input)
// -----------------------------------------------------------------------------
module tt_um_felixfeierabend_mux
  import tt_um_felixfeierabend_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Control fields decoded from the bidirectional inputs.
  sel_e       sel;
  logic       load;
  logic       invert;

  assign sel    = sel_e'(uio_in[5:4]);
  assign load   = uio_in[6];
  assign invert = uio_in[7];

  // uio_in[3:0] are output pads and carry no information for this design.
  logic unused_uio_low;
  assign unused_uio_low = &{1'b0, uio_in[3:0]};

  logic [7:0] uo_reg;
  logic [1:0] sel_echo_reg;
  logic [7:0] cnt_reg;
  logic       wrap_reg;
  logic [7:0] hold_reg;
  logic       hold_valid_reg;
  logic [7:0] lfsr_q;
  logic [7:0] mux_src;
  logic [7:0] uo_next;

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .q     (lfsr_q)
  );

  // Source select. The hold source is the register's current contents, so a
  // load issued in the same cycle only becomes visible one cycle later.
  always_comb begin
    mux_src = ui_in;
    case (sel)
      SEL_UI:   mux_src = ui_in;
      SEL_HOLD: mux_src = hold_reg;
      SEL_CNT:  mux_src = cnt_reg;
      SEL_LFSR: mux_src = lfsr_q;
      default:  mux_src = ui_in;
    endcase
  end

  assign uo_next = mux_src ^ {8{invert}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_reg         <= 8'h00;
      sel_echo_reg   <= 2'd0;
      cnt_reg        <= 8'h00;
      wrap_reg       <= 1'b0;
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
    end else if (ena) begin
      uo_reg       <= uo_next;
      sel_echo_reg <= uio_in[5:4];
      cnt_reg      <= cnt_reg + 8'd1;
      // Raised on the edge where the counter rolls FF->00, so it is high for
      // the single enabled cycle that follows the rollover.
      wrap_reg     <= (cnt_reg == 8'hFF);
      if (load) begin
        hold_reg       <= ui_in;
        hold_valid_reg <= 1'b1;
      end
    end
  end

  assign uo_out  = uo_reg;
  assign uio_out = {4'b0000, sel_echo_reg, hold_valid_reg, wrap_reg};
  assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_tt_um_felixfeierabend_mux.sv
// -----------------------------------------------------------------------------
// tb_tt_um_felixfeierabend_mux
// Directed stimulus with a scoreboard: each driven cycle pushes the expected
// registered response; a monitor on the falling edge pops and compares.
// Asynchronous reset effects are checked directly between clock edges.
// -----------------------------------------------------------------------------
module tb_tt_um_felixfeierabend_mux;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_felixfeierabend_mux dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: the response to a cycle driven after falling edge N is visible
  // at falling edge N+1.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("[TB] %s: uo_out=%h uio_out=%h uio_oe=%h", e.name, uo_out, uio_out, uio_oe);
        check({e.name, ".uo_out"}, uo_out, e.uo);
        check({e.name, ".uio_out"}, uio_out, e.uio);
        check({e.name, ".uio_oe"}, uio_oe, 8'h0F);
      end
    end
  end

  task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic en,
                      input logic [7:0] exp_uo, input logic [7:0] exp_uio, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    ui_in  = ui;
    uio_in = uio;
    ena    = en;
    e.name = nm;
    e.uo   = exp_uo;
    e.uio  = exp_uio;
    sb.push_back(e);
  endtask

  task automatic check_reset_values(input string nm);
    $display("[TB] %s: uo_out=%h uio_out=%h uio_oe=%h", nm, uo_out, uio_out, uio_oe);
    check({nm, ".uo_out"}, uo_out, 8'h00);
    check({nm, ".uio_out"}, uio_out, 8'h00);
    check({nm, ".uio_oe"}, uio_oe, 8'h0F);
  endtask

  // Reset pulse asserted between clock edges; outputs must clear at once.
  task automatic pulse_reset(input string nm);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values(nm);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [7:0] LFSR_SEQ [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset held for 10 cycles, then release and pass ui_in through.
    repeat (10) @(negedge clk);
    #1;
    check_reset_values("in_reset");
    rst_n = 1'b1;
    step(8'h01, 8'h00, 1'b1, 8'h01, 8'h00, "pass_01");
    step(8'h3C, 8'h80, 1'b1, 8'hC3, 8'h00, "pass_inv");
    step(8'h3C, 8'h00, 1'b0, 8'hC3, 8'h00, "pass_frozen");

    // LFSR sequence from reset, freeze, resume.
    pulse_reset("reset_pre_lfsr");
    for (int i = 0; i < 6; i++)
      step(8'h00, 8'h30, 1'b1, LFSR_SEQ[i], 8'h0C, $sformatf("lfsr_%0d", i));
    for (int i = 0; i < 3; i++)
      step(8'h00, 8'h30, 1'b0, 8'h23, 8'h0C, $sformatf("lfsr_hold_%0d", i));
    step(8'h00, 8'h30, 1'b1, 8'h47, 8'h0C, "lfsr_resume");

    // Mid-operation reset: LFSR must restart at 01.
    pulse_reset("reset_mid_lfsr");
    step(8'h00, 8'h30, 1'b1, 8'h01, 8'h0C, "lfsr_restart_0");
    step(8'h00, 8'h30, 1'b1, 8'h02, 8'h0C, "lfsr_restart_1");

    // Counter over 257 enabled edges: FF then 00, wrap flag with the FF edge.
    pulse_reset("reset_pre_cnt");
    for (int i = 0; i < 257; i++) begin
      logic [7:0] cval;
      cval = 8'(i);
      step(8'h00, 8'h20, 1'b1, cval, (i == 255) ? 8'h09 : 8'h08, $sformatf("cnt_%0d", i));
    end

    // Hold register: load, select, invert, same-cycle load+select, frozen load.
    step(8'hA5, 8'h40, 1'b1, 8'hA5, 8'h02, "hold_load_a5");
    step(8'h00, 8'h10, 1'b1, 8'hA5, 8'h06, "hold_sel");
    step(8'h00, 8'h90, 1'b1, 8'h5A, 8'h06, "hold_inv");
    step(8'h3C, 8'h50, 1'b1, 8'hA5, 8'h06, "hold_load_sel_old");
    step(8'h00, 8'h10, 1'b1, 8'h3C, 8'h06, "hold_load_sel_new");
    step(8'hFF, 8'h50, 1'b0, 8'h3C, 8'h06, "hold_load_disabled");
    step(8'h00, 8'h10, 1'b1, 8'h3C, 8'h06, "hold_unchanged");
    // Counter has seen 257 + 6 enabled edges since reset -> value 07.
    step(8'h00, 8'h20, 1'b1, 8'h07, 8'h0A, "sel_switch_cnt");
    step(8'h00, 8'hA0, 1'b1, 8'hF7, 8'h0A, "sel_cnt_inv");

    // Final reset clears sticky hold_valid too.
    pulse_reset("reset_final");

    @(negedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_felixfeierabend_mux.md
TT_UM_FELIXFEIERABEND_MUX -- requirements
Module: tt_um_felixfeierabend_mux

Interface
REQ-001 clk  input  1  single system clock; all state rising-edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 ena  input  1  design enable; low freezes all state.
REQ-004 ui_in  input  8  data input; mux source 0, hold-register load data.
REQ-005 uio_in  input  8  [5:4] sel, [6] load, [7] invert; [3:0] ignored.
REQ-006 uo_out  output  8  registered mux result.
REQ-007 uio_out  output  8  [0] wrap pulse, [1] hold_valid, [3:2] sel echo, [7:4] driven 0.
REQ-008 uio_oe  output  8  constant 8'h0F, with [3:0] as outputs and [7:4] as inputs.

Function
REQ-009 Sources by sel: 0=ui_in, 1=hold register, 2=free-running counter, 3=LFSR.
REQ-010 uo_out SHALL update on each enabled edge to (selected source XOR {8{invert}}), giving 1-cycle latency from ui_in/uio_in.
REQ-011 ena=0 SHALL hold uo_out, counter, LFSR, hold register and status flags unchanged.
REQ-012 Counter SHALL be 8-bit, increment by 1 per enabled cycle, and wrap FF->00.
REQ-013 uio_out[0] SHALL be high for exactly one enabled cycle: the cycle after the counter steps FF->00.
REQ-014 LFSR SHALL be 8-bit Fibonacci and shift per enabled cycle, next = {q[6:0], q[7]^q[5]^q[4]^q[3]}, reaching 255 states without ever 00.
REQ-015 load=1 with ena=1 SHALL capture ui_in into the hold register and set hold_valid (uio_out[1]); hold_valid is sticky until reset.
REQ-016 Simultaneous load=1 and sel=1 SHALL output the pre-load hold value that cycle; the new value appears one cycle later.
REQ-017 uio_out[3:2] SHALL be the sel value registered alongside uo_out.
REQ-018 Changing sel or invert mid-stream SHALL take effect on the next enabled edge with no glitch cycles or extra latency.

Reset
REQ-019 rst_n=0 SHALL immediately force uo_out=00, counter=00, hold=00, hold_valid=0, wrap=0 and sel echo=0, with LFSR=8'h01, independent of clk and ena.
REQ-020 uio_oe SHALL read 8'h0F during and after reset.
REQ-021 First enabled edge after reset release SHALL apply normal operation; there are no extra wait cycles.

Structure
REQ-022 A shared package SHALL hold sel encodings (SEL_UI, SEL_HOLD, SEL_CNT, SEL_LFSR), LFSR_SEED=8'h01, LFSR tap mask, and UIO_OE=8'h0F.
REQ-023 One sub-module lfsr8 (clk, rst_n, en, q[7:0]) SHALL implement REQ-014; everything else resides in the top.

Verification
REQ-024 Reset asserted, ui_in=00, uio_in=00, then release and ena=1 at +10 cycles, then ui_in=8'h01 -> uo_out=8'h01 one edge later; uio_oe=8'h0F throughout.
REQ-025 sel=3, ena=1 from reset -> uo_out sequence 01,02,04,08,11,23 on successive edges; ena=0 for 3 cycles -> value frozen.
REQ-026 sel=2 from reset for 257 enabled edges -> uo_out passes FF then 00; uio_out[0] high for exactly one cycle after the wrap.
REQ-027 ui_in=8'hA5, load=1 for one cycle, then ui_in=8'h00, sel=1 -> uo_out=8'hA5 and uio_out[1]=1; invert=1 -> uo_out=8'h5A next edge.
REQ-028 Mid-operation rst_n pulse between clock edges -> all outputs at reset values immediately, LFSR restarts at 01.
